radiant_event_readout: RTL and testbench

Responder end of the event-ready handshake. It accepts an `event_ready` request from the trigger/event-control side and answers with a one-cycle `event_readout_ready` pulse. It then drains the event header from the event FIFO and the sample words of every enabled channel into a 32-bit DMA stream. Finally it reports `readout_running`, `readout_done` and per-channel buffer-full status back to the trigger overlord.

---
 rtl/radiant_readout_pkg.sv | 23 ++
 rtl/radiant_readout_skid.sv | 69 ++++++
 rtl/radiant_event_readout.sv | 217 +++++++++++++++++++++
 tb/tb_radiant_event_readout.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/radiant_readout_pkg.sv
// Purpose: shared types and defaults for the RADIANT event readout block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package radiant_readout_pkg;

    // Readout sequencer states, in the order an event passes through them.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACK   = 3'd1,
        ST_HDR   = 3'd2,
        ST_CHAN  = 3'd3,
        ST_FLUSH = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Width of the sample-buffer channel select.
    localparam int CH_SEL_W = 5;

    // Default event geometry.
    localparam int HDR_WORDS_DEF    = 4;
    localparam int WORDS_PER_CH_DEF = 1024;

endpackage

// File: rtl/radiant_readout_skid.sv
// Purpose: 2-entry skid buffer carrying {last, data} onto the DMA stream.
// Latency: 1 cycle from in_vld to out_vld when empty.
// Backpressure: holds out_* stable while out_vld && !out_rdy; the caller keeps
//   (occupancy + reads in flight) below 2, so no overflow guard is needed here.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_vld, in_dat, in_last    word arriving from a memory read (no ready)
//   out_vld, out_dat, out_last head entry presented to the stream
//   out_rdy                    stream ready
//   occ                        number of valid entries (0..2)
module radiant_readout_skid (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_vld,
    input  logic [31:0] in_dat,
    input  logic        in_last,
    output logic        out_vld,
    output logic [31:0] out_dat,
    output logic        out_last,
    input  logic        out_rdy,
    output logic [1:0]  occ
);

    // Entry 0 is the head and drives the outputs directly; entry 1 is only
    // ever valid while entry 0 is valid.
    logic        v0, v1;
    logic [31:0] d0, d1;
    logic        l0, l1;
    logic        pop;

    assign pop      = v0 && out_rdy;
    assign out_vld  = v0;
    assign out_dat  = d0;
    assign out_last = l0;
    assign occ      = {v0 & v1, v0 ^ v1};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            d0 <= '0;
            d1 <= '0;
            l0 <= 1'b0;
            l1 <= 1'b0;
        end else begin
            if (pop) begin
                v0 <= v1;
                d0 <= d1;
                l0 <= l1;
                v1 <= 1'b0;
            end
            // A push lands in the head slot if the head is free after this
            // cycle's pop, otherwise behind it. Later assignments win.
            if (in_vld) begin
                if (!v0 || (pop && !v1)) begin
                    v0 <= 1'b1;
                    d0 <= in_dat;
                    l0 <= in_last;
                end else begin
                    v1 <= 1'b1;
                    d1 <= in_dat;
                    l1 <= in_last;
                end
            end
        end
    end

endmodule

// File: rtl/radiant_event_readout.sv
// Purpose: event-ready responder; streams header + enabled channel samples to DMA.
// Latency: ACK 1 cycle after request, first read 2, first stream word 4; 1 word/cycle.
// Backpressure: reads throttled so skid occupancy + reads in flight stays below 2.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-low reset
//   event_ready_i / event_readout_ready_o   request level / one-cycle accept pulse
//   event_fifo_*                  header source, read data valid one cycle after strobe
//   chan_mask_i                   channels to read out (latched at accept)
//   buf_rd_o/buf_ch_o/buf_addr_o/buf_dat_i  sample buffer read port, 1-cycle latency
//   dma_*                         32-bit valid/ready stream with end-of-event marker
//   buffer_written_i, readout_full_thresh_i, readout_*_o   status to the trigger side
module radiant_event_readout
    import radiant_readout_pkg::*;
#(
    parameter int NUM_CH       = 24,
    parameter int HDR_WORDS    = HDR_WORDS_DEF,
    parameter int WORDS_PER_CH = WORDS_PER_CH_DEF,
    parameter int PEND_WIDTH   = 12,
    localparam int ADDR_W      = $clog2(WORDS_PER_CH),
    localparam int HCNT_W      = $clog2(HDR_WORDS + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  event_ready_i,
    output logic                  event_readout_ready_o,
    output logic                  event_fifo_rd_o,
    input  logic [31:0]           event_fifo_dat_i,
    input  logic                  event_fifo_empty_i,
    input  logic [NUM_CH-1:0]     chan_mask_i,
    output logic                  buf_rd_o,
    output logic [CH_SEL_W-1:0]   buf_ch_o,
    output logic [ADDR_W-1:0]     buf_addr_o,
    input  logic [31:0]           buf_dat_i,
    output logic [31:0]           dma_dat_o,
    output logic                  dma_valid_o,
    output logic                  dma_last_o,
    input  logic                  dma_ready_i,
    input  logic                  buffer_written_i,
    input  logic [PEND_WIDTH-1:0] readout_full_thresh_i,
    output logic                  readout_running_o,
    output logic                  readout_done_o,
    output logic [NUM_CH-1:0]     readout_full_o
);

    state_t                state;
    logic                  armed;
    logic [NUM_CH-1:0]     mask_r;
    logic [CH_SEL_W-1:0]   ch;
    logic [ADDR_W-1:0]     addr;
    logic [HCNT_W-1:0]     hdr_cnt;
    logic [PEND_WIDTH-1:0] pending;

    // One read may be in flight; its source and end-of-event tag travel with it.
    logic                  inflight;
    logic                  inflight_hdr;
    logic                  inflight_last;

    logic [1:0]            occ;
    logic                  pop;
    logic [2:0]            occ_eff;
    logic [2:0]            load;
    logic                  can_issue;
    logic                  hdr_rd;
    logic                  buf_rd;
    logic                  rd_last;
    logic                  hdr_last_word;
    logic                  ch_last_word;
    logic                  flush_done;
    logic [CH_SEL_W:0]     first_sel;
    logic [CH_SEL_W:0]     next_sel;

    // Lowest set bit of m at or above index start; MSB of the result is "found".
    function automatic logic [CH_SEL_W:0] find_set(input logic [NUM_CH-1:0] m,
                                                   input int start);
        logic [CH_SEL_W:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i] && i >= start) r = {1'b1, CH_SEL_W'(i)};
        end
        return r;
    endfunction

    assign first_sel = find_set(chan_mask_i, 0);
    assign next_sel  = find_set(mask_r, int'(ch) + 1);

    // Occupancy is taken after this cycle's pop so a word leaving the skid
    // frees room for a new read in the same cycle (1 word/cycle sustained).
    assign pop       = dma_valid_o && dma_ready_i;
    assign occ_eff   = {1'b0, occ} - {2'b00, pop};
    assign load      = occ_eff + {2'b00, inflight};
    assign can_issue = (load < 3'd2);

    assign hdr_rd = (state == ST_HDR) && !event_fifo_empty_i && can_issue;
    assign buf_rd = (state == ST_CHAN) && can_issue;

    assign hdr_last_word = (hdr_cnt == HCNT_W'(HDR_WORDS - 1));
    assign ch_last_word  = (addr == ADDR_W'(WORDS_PER_CH - 1));

    // The final word of an event is either the last sample of the highest
    // enabled channel or, with nothing enabled, the last header word.
    assign rd_last = (hdr_rd && hdr_last_word && (mask_r == '0)) ||
                     (buf_rd && ch_last_word && !next_sel[CH_SEL_W]);

    // Skid drained and nothing in flight: the last-tagged word has been taken.
    assign flush_done = (occ_eff == 3'd0) && !inflight;

    assign event_fifo_rd_o = hdr_rd;
    assign buf_rd_o        = buf_rd;
    assign buf_ch_o        = ch;
    assign buf_addr_o      = addr;

    radiant_readout_skid u_skid (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .in_vld   (inflight),
        .in_dat   (inflight_hdr ? event_fifo_dat_i : buf_dat_i),
        .in_last  (inflight_last),
        .out_vld  (dma_valid_o),
        .out_dat  (dma_dat_o),
        .out_last (dma_last_o),
        .out_rdy  (dma_ready_i),
        .occ      (occ)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state                 <= ST_IDLE;
            armed                 <= 1'b1;
            mask_r                <= '0;
            ch                    <= '0;
            addr                  <= '0;
            hdr_cnt               <= '0;
            inflight              <= 1'b0;
            inflight_hdr          <= 1'b0;
            inflight_last         <= 1'b0;
            event_readout_ready_o <= 1'b0;
            readout_running_o     <= 1'b0;
            readout_done_o        <= 1'b0;
        end else begin
            event_readout_ready_o <= 1'b0;
            readout_done_o        <= 1'b0;
            inflight              <= hdr_rd | buf_rd;
            inflight_hdr          <= hdr_rd;
            inflight_last         <= rd_last;

            case (state)
                ST_IDLE: begin
                    if (event_ready_i && armed) begin
                        state                 <= ST_ACK;
                        event_readout_ready_o <= 1'b1;
                        readout_running_o     <= 1'b1;
                    end
                end
                ST_ACK: begin
                    armed   <= 1'b0;
                    mask_r  <= chan_mask_i;
                    hdr_cnt <= '0;
                    addr    <= '0;
                    ch      <= first_sel[CH_SEL_W] ? first_sel[CH_SEL_W-1:0] : '0;
                    state   <= ST_HDR;
                end
                ST_HDR: begin
                    if (hdr_rd) begin
                        hdr_cnt <= hdr_cnt + 1'b1;
                        if (hdr_last_word) begin
                            state <= (mask_r == '0) ? ST_FLUSH : ST_CHAN;
                        end
                    end
                end
                ST_CHAN: begin
                    if (buf_rd) begin
                        if (ch_last_word) begin
                            addr <= '0;
                            if (next_sel[CH_SEL_W]) ch <= next_sel[CH_SEL_W-1:0];
                            else                    state <= ST_FLUSH;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_done) begin
                        state          <= ST_DONE;
                        readout_done_o <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state             <= ST_IDLE;
                    readout_running_o <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase

            // Re-arm whenever the request is low; this wins over the clear in
            // ACK so a request dropped during ACK is not treated as held.
            if (!event_ready_i) armed <= 1'b1;
        end
    end

    // Pending-buffer counter and full flags.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pending        <= '0;
            readout_full_o <= '0;
        end else begin
            if (buffer_written_i && (state != ST_DONE)) begin
                if (pending != '1) pending <= pending + 1'b1;
            end else if (!buffer_written_i && (state == ST_DONE)) begin
                if (pending != '0) pending <= pending - 1'b1;
            end
            readout_full_o <= ((readout_full_thresh_i != '0) &&
                               (pending >= readout_full_thresh_i)) ? chan_mask_i : '0;
        end
    end

endmodule

// File: tb/tb_radiant_event_readout.sv
module tb_radiant_event_readout;

    localparam int NUM_CH = 24;
    localparam int HW     = 4;
    localparam int WPC    = 8;
    localparam int PW     = 12;

    logic          clk_i;
    logic          rst_i;
    logic          event_ready_i;
    logic          event_readout_ready_o;
    logic          event_fifo_rd_o;
    logic [31:0]   event_fifo_dat_i;
    logic          event_fifo_empty_i;
    logic [23:0]   chan_mask_i;
    logic          buf_rd_o;
    logic [4:0]    buf_ch_o;
    logic [2:0]    buf_addr_o;
    logic [31:0]   buf_dat_i;
    logic [31:0]   dma_dat_o;
    logic          dma_valid_o;
    logic          dma_last_o;
    logic          dma_ready_i;
    logic          buffer_written_i;
    logic [PW-1:0] readout_full_thresh_i;
    logic          readout_running_o;
    logic          readout_done_o;
    logic [23:0]   readout_full_o;

    radiant_event_readout #(
        .NUM_CH(NUM_CH), .HDR_WORDS(HW), .WORDS_PER_CH(WPC), .PEND_WIDTH(PW)
    ) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .event_ready_i         (event_ready_i),
        .event_readout_ready_o (event_readout_ready_o),
        .event_fifo_rd_o       (event_fifo_rd_o),
        .event_fifo_dat_i      (event_fifo_dat_i),
        .event_fifo_empty_i    (event_fifo_empty_i),
        .chan_mask_i           (chan_mask_i),
        .buf_rd_o              (buf_rd_o),
        .buf_ch_o              (buf_ch_o),
        .buf_addr_o            (buf_addr_o),
        .buf_dat_i             (buf_dat_i),
        .dma_dat_o             (dma_dat_o),
        .dma_valid_o           (dma_valid_o),
        .dma_last_o            (dma_last_o),
        .dma_ready_i           (dma_ready_i),
        .buffer_written_i      (buffer_written_i),
        .readout_full_thresh_i (readout_full_thresh_i),
        .readout_running_o     (readout_running_o),
        .readout_done_o        (readout_done_o),
        .readout_full_o        (readout_full_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [23:0] mask;
        int          pct;
        int          empty;
        int          beats;
        int          run;
        bit          hold;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    int cyc       = 0;
    int pct       = 100;
    int empty_cnt = 0;
    int bw_pulses = 0;
    bit bw_on_done = 1'b0;
    int hdr_idx   = 0;

    bit          rd_prev, brd_prev;
    logic [4:0]  ch_prev;
    logic [2:0]  addr_prev;
    bit          stall_prev;
    logic [31:0] stall_dat;
    logic        stall_last;

    logic [31:0] exp_q[$];
    logic [4:0]  ch_seq[$];
    int beats, last_cnt, last_beat, last_cyc, done_cnt, done_cyc;
    int ack_cnt, ack_cyc, run_cnt, first_rd_cyc, first_vld_cyc, rd_empty_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        beats = 0; last_cnt = 0; last_beat = -1; last_cyc = -1;
        done_cnt = 0; done_cyc = -1; ack_cnt = 0; ack_cyc = -1; run_cnt = 0;
        first_rd_cyc = -1; first_vld_cyc = -1; rd_empty_cnt = 0;
        ch_seq.delete();
    endtask

    // Expected stream: header counting pattern, then {B0, ch, addr} per word.
    task automatic build_exp(input logic [23:0] mask);
        exp_q.delete();
        for (int k = 0; k < HW; k++) exp_q.push_back(32'hA500_0000 + 32'(hdr_idx + k));
        for (int c = 0; c < NUM_CH; c++)
            if (mask[c])
                for (int a = 0; a < WPC; a++)
                    exp_q.push_back({8'hB0, 3'b000, 5'(c), 13'd0, 3'(a)});
    endtask

    // One clock: sources respond after the edge, outputs sampled at negedge.
    task automatic step();
        @(posedge clk_i);
        #1;
        if (rd_prev) begin
            event_fifo_dat_i = 32'hA500_0000 + 32'(hdr_idx);
            hdr_idx++;
        end else begin
            event_fifo_dat_i = $urandom;
        end
        if (brd_prev) buf_dat_i = {8'hB0, 3'b000, ch_prev, 13'd0, addr_prev};
        else          buf_dat_i = $urandom;
        dma_ready_i        = (int'($urandom_range(0, 99)) < pct);
        event_fifo_empty_i = (empty_cnt > 0);
        if (empty_cnt > 0) empty_cnt--;
        buffer_written_i   = (bw_on_done && readout_done_o) || (bw_pulses > 0);
        if (bw_pulses > 0) bw_pulses--;
        @(negedge clk_i);
        cyc++;
        if (stall_prev) begin
            checks++;
            if (!(dma_valid_o && dma_dat_o == stall_dat && dma_last_o == stall_last)) begin
                failures++;
                $display("FAIL stall_hold: got vld=%0b dat=0x%08h last=%0b expected vld=1 dat=0x%08h last=%0b",
                         dma_valid_o, dma_dat_o, dma_last_o, stall_dat, stall_last);
            end
        end
        stall_prev = dma_valid_o && !dma_ready_i;
        stall_dat  = dma_dat_o;
        stall_last = dma_last_o;
        if (dma_valid_o && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (dma_valid_o && dma_ready_i) begin
            beats++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL beat_extra: got 0x%08h expected no beat", dma_dat_o);
            end else begin
                check("beat_data", dma_dat_o, exp_q.pop_front());
            end
            if (dma_last_o) begin
                last_cnt++;
                last_beat = beats;
                last_cyc  = cyc;
            end
        end
        if (event_fifo_rd_o && event_fifo_empty_i) rd_empty_cnt++;
        if (event_fifo_rd_o && first_rd_cyc < 0) first_rd_cyc = cyc;
        if (buf_rd_o && buf_addr_o == 3'd0) ch_seq.push_back(buf_ch_o);
        rd_prev   = event_fifo_rd_o;
        brd_prev  = buf_rd_o;
        ch_prev   = buf_ch_o;
        addr_prev = buf_addr_o;
        if (event_readout_ready_o) begin
            ack_cnt++;
            if (ack_cyc < 0) ack_cyc = cyc;
        end
        if (readout_done_o) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        if (readout_running_o) run_cnt++;
    endtask

    task automatic run_event(input string nm, input logic [23:0] mask, input int p,
                             input int empty, input int exp_beats, input int exp_run,
                             input bit hold);
        int guard;
        int j;
        clear_stats();
        build_exp(mask);
        chan_mask_i   = mask;
        pct           = p;
        empty_cnt     = empty;
        event_ready_i = 1'b1;
        guard = 0;
        while (done_cyc < 0 && guard < 3000) begin
            step();
            guard++;
            if (ack_cnt > 0 && !hold) event_ready_i = 1'b0;
        end
        if (done_cyc < 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no readout_done_o expected done within 3000 cycles", nm);
        end
        step();
        step();
        check({nm, "_ack_count"},   32'(ack_cnt), 32'd1);
        check({nm, "_rd_latency"},  32'(first_rd_cyc - ack_cyc), 32'((empty > 1) ? empty : 1));
        check({nm, "_vld_latency"}, 32'(first_vld_cyc - first_rd_cyc), 32'd2);
        check({nm, "_beats"},       32'(beats), 32'(exp_beats));
        check({nm, "_exp_left"},    32'(exp_q.size()), 32'd0);
        check({nm, "_last_count"},  32'(last_cnt), 32'd1);
        check({nm, "_last_pos"},    32'(last_beat), 32'(exp_beats));
        check({nm, "_done_lat"},    32'(done_cyc - last_cyc), 32'd1);
        check({nm, "_done_count"},  32'(done_cnt), 32'd1);
        check({nm, "_rd_on_empty"}, 32'(rd_empty_cnt), 32'd0);
        j = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (mask[c]) begin
                if (j < ch_seq.size()) check({nm, "_ch_order"}, 32'(ch_seq[j]), 32'(c));
                j++;
            end
        end
        check({nm, "_ch_count"}, 32'(ch_seq.size()), 32'(j));
        if (exp_run != 0) check({nm, "_running"}, 32'(run_cnt), 32'(exp_run));
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_dma_dat"},   dma_dat_o, 32'd0);
        check({nm, "_dma_valid"}, 32'(dma_valid_o), 32'd0);
        check({nm, "_dma_last"},  32'(dma_last_o), 32'd0);
        check({nm, "_running"},   32'(readout_running_o), 32'd0);
        check({nm, "_done"},      32'(readout_done_o), 32'd0);
        check({nm, "_ack"},       32'(event_readout_ready_o), 32'd0);
        check({nm, "_fifo_rd"},   32'(event_fifo_rd_o), 32'd0);
        check({nm, "_buf_rd"},    32'(buf_rd_o), 32'd0);
        check({nm, "_buf_ch"},    32'(buf_ch_o), 32'd0);
        check({nm, "_buf_addr"},  32'(buf_addr_o), 32'd0);
        check({nm, "_full"},      32'(readout_full_o), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        int guard;
        bit found;

        //        mask          pct empty beats run  hold
        vecs[0] = '{24'h000001, 100, 0,   12,   16,  1'b0};
        vecs[1] = '{24'h800005, 100, 0,   28,   32,  1'b0};
        vecs[2] = '{24'h000006, 30,  0,   20,   0,   1'b0};
        vecs[3] = '{24'h000000, 100, 0,   4,    8,   1'b0};
        vecs[4] = '{24'hFFFFFF, 100, 0,   196,  200, 1'b0};
        vecs[5] = '{24'h800000, 50,  3,   12,   0,   1'b0};

        rst_i = 1'b0; event_ready_i = 1'b0; event_fifo_dat_i = '0; event_fifo_empty_i = 1'b0;
        chan_mask_i = '0; buf_dat_i = '0; dma_ready_i = 1'b1; buffer_written_i = 1'b0;
        readout_full_thresh_i = '0;
        rd_prev = 1'b0; brd_prev = 1'b0; ch_prev = '0; addr_prev = '0; stall_prev = 1'b0;
        stall_dat = '0; stall_last = 1'b0;
        clear_stats();

        for (int i = 0; i < 3; i++) step();
        check_zero("reset");
        rst_i = 1'b1;
        step();

        for (int i = 0; i < 6; i++)
            run_event($sformatf("v%0d", i), vecs[i].mask, vecs[i].pct, vecs[i].empty,
                      vecs[i].beats, vecs[i].run, vecs[i].hold);

        // Request held high across DONE: one ACK only; a 1-cycle drop re-arms.
        run_event("hold", 24'h000010, 100, 0, 12, 16, 1'b1);
        clear_stats();
        for (int i = 0; i < 6; i++) step();
        check("hold_no_reack", 32'(ack_cnt), 32'd0);
        event_ready_i = 1'b0;
        step();
        run_event("rearm", 24'h000010, 100, 0, 12, 16, 1'b0);

        // Pending counter and full flags.
        chan_mask_i = 24'h000005;
        readout_full_thresh_i = 12'd3;
        bw_pulses = 2;
        for (int i = 0; i < 4; i++) step();
        check("full_pend2", 32'(readout_full_o), 32'h0);
        bw_pulses = 1;
        for (int i = 0; i < 3; i++) step();
        check("full_pend3", 32'(readout_full_o), 32'h5);
        bw_on_done = 1'b1;
        run_event("coinc", 24'h000005, 100, 0, 20, 24, 1'b0);
        bw_on_done = 1'b0;
        check("full_after_coinc", 32'(readout_full_o), 32'h5);
        chan_mask_i = 24'h800001;
        step(); step();
        check("full_live_mask", 32'(readout_full_o), 32'h800001);
        chan_mask_i = 24'h000005;
        readout_full_thresh_i = 12'd0;
        step(); step();
        check("full_thresh0", 32'(readout_full_o), 32'h0);
        readout_full_thresh_i = 12'd3;
        run_event("dec", 24'h000005, 100, 0, 20, 24, 1'b0);
        check("full_pend2b", 32'(readout_full_o), 32'h0);
        readout_full_thresh_i = 12'd2;
        step(); step();
        check("full_thresh2", 32'(readout_full_o), 32'h5);
        run_event("dec1", 24'h000005, 100, 0, 20, 0, 1'b0);
        run_event("dec0", 24'h000005, 100, 0, 20, 0, 1'b0);
        run_event("sat0", 24'h000005, 100, 0, 20, 0, 1'b0);
        readout_full_thresh_i = 12'd1;
        step(); step();
        check("full_sat0", 32'(readout_full_o), 32'h0);
        bw_pulses = 1;
        for (int i = 0; i < 3; i++) step();
        check("full_pend1", 32'(readout_full_o), 32'h5);
        readout_full_thresh_i = 12'd0;

        // Reset mid-CHAN, then an event whose header FIFO starts empty.
        clear_stats();
        build_exp(24'h800005);
        chan_mask_i = 24'h800005;
        pct = 100;
        event_ready_i = 1'b1;
        found = 1'b0;
        guard = 0;
        while (!found && guard < 200) begin
            step();
            guard++;
            if (ack_cnt > 0) event_ready_i = 1'b0;
            if (buf_rd_o && buf_ch_o == 5'd2) found = 1'b1;
        end
        check("abort_reached_ch2", 32'(found), 32'd1);
        rst_i = 1'b0;
        step();
        step();
        check_zero("abort");
        check("abort_no_last", 32'(last_cnt), 32'd0);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        rst_i = 1'b1;
        exp_q.delete();
        step();
        run_event("stall_hdr", 24'h000003, 100, 10, 20, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
